// File: rtl/gpu_pkg.sv
// Shared GPU constants, rasterizer state encoding and pixel payload.
package gpu_pkg;

   localparam int unsigned COORD_W  = 10;
   localparam int unsigned COLOR_W  = 16;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 400;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      DRAW  = 2'd2
   } rast_state_t;

   typedef struct packed {
      logic [COORD_W-1:0] x;
      logic [COORD_W-1:0] y;
      logic [COLOR_W-1:0] color;
      logic               last;
   } pixel_t;

endpackage

// File: rtl/line_rasterizer.sv
// Bresenham line rasterizer: one line command in, a clipped (x, y, colour) pixel stream out.
module line_rasterizer
   import gpu_pkg::*;
(
   input  logic               I_CLK,
   input  logic               I_RST,
   input  logic               I_CMD_VALID,
   output logic               O_CMD_READY,
   input  logic [COORD_W-1:0] I_X0,
   input  logic [COORD_W-1:0] I_Y0,
   input  logic [COORD_W-1:0] I_X1,
   input  logic [COORD_W-1:0] I_Y1,
   input  logic [COLOR_W-1:0] I_COLOR,
   output logic               O_PIX_VALID,
   input  logic               I_PIX_READY,
   output logic [COORD_W-1:0] O_PIX_X,
   output logic [COORD_W-1:0] O_PIX_Y,
   output logic [COLOR_W-1:0] O_PIX_COLOR,
   output logic               O_PIX_LAST,
   output logic               O_DONE,
   output logic               O_BUSY
);

   localparam int unsigned DX_W  = COORD_W + 1;
   localparam int unsigned DY_W  = COORD_W + 2;
   localparam int unsigned ERR_W = COORD_W + 3;
   localparam int unsigned E2_W  = COORD_W + 4;

   rast_state_t r_state;
   rast_state_t w_state_nxt;

   logic [COORD_W-1:0]     r_cur_x, r_cur_y, r_x1, r_y1;
   logic [COLOR_W-1:0]     r_color;
   logic [DX_W-1:0]        r_dx;
   logic signed [DY_W-1:0] r_dy;
   logic signed [ERR_W-1:0] r_err;
   logic                   r_sx_neg, r_sy_neg;

   logic                   w_in_bounds, w_at_end, w_step, w_draw;
   logic                   w_step_x, w_step_y;
   logic [DX_W-1:0]        w_dx_abs, w_dy_abs;
   logic signed [DY_W-1:0] w_dy_neg;
   logic signed [E2_W-1:0] w_err_e, w_e2, w_dx_e, w_dy_e, w_err_nxt;
   pixel_t                 w_pix;

   // Setup-time deltas; cur already holds (x0, y0) after the command is latched.
   assign w_dx_abs = (r_x1 >= r_cur_x) ? (DX_W'(r_x1) - DX_W'(r_cur_x))
                                       : (DX_W'(r_cur_x) - DX_W'(r_x1));
   assign w_dy_abs = (r_y1 >= r_cur_y) ? (DX_W'(r_y1) - DX_W'(r_cur_y))
                                       : (DX_W'(r_cur_y) - DX_W'(r_y1));
   assign w_dy_neg = -$signed({1'b0, w_dy_abs});

   assign w_draw      = (r_state == DRAW);
   assign w_in_bounds = (r_cur_x < COORD_W'(SCREEN_W)) && (r_cur_y < COORD_W'(SCREEN_H));
   assign w_at_end    = (r_cur_x == r_x1) && (r_cur_y == r_y1);
   // Clipped pixels advance without waiting for the writer.
   assign w_step      = w_draw && (!w_in_bounds || I_PIX_READY);

   assign w_err_e  = E2_W'(r_err);
   assign w_e2     = w_err_e <<< 1;
   assign w_dx_e   = $signed(E2_W'(r_dx));
   assign w_dy_e   = E2_W'(r_dy);
   assign w_step_x = (w_e2 >= w_dy_e);
   assign w_step_y = (w_e2 <= w_dx_e);

   always_comb begin
      w_err_nxt = w_err_e;
      if (w_step_x) w_err_nxt = w_err_nxt + w_dy_e;
      if (w_step_y) w_err_nxt = w_err_nxt + w_dx_e;
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) r_state <= IDLE;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (I_CMD_VALID) w_state_nxt = SETUP;
         SETUP:   w_state_nxt = DRAW;
         DRAW:    if (w_step && w_at_end) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_RST) begin
         r_cur_x  <= '0;
         r_cur_y  <= '0;
         r_x1     <= '0;
         r_y1     <= '0;
         r_color  <= '0;
         r_dx     <= '0;
         r_dy     <= '0;
         r_err    <= '0;
         r_sx_neg <= 1'b0;
         r_sy_neg <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (I_CMD_VALID) begin
                  r_cur_x <= I_X0;
                  r_cur_y <= I_Y0;
                  r_x1    <= I_X1;
                  r_y1    <= I_Y1;
                  r_color <= I_COLOR;
               end
            end
            SETUP: begin
               r_dx     <= w_dx_abs;
               r_dy     <= w_dy_neg;
               r_err    <= $signed({2'b00, w_dx_abs}) + ERR_W'(w_dy_neg);
               r_sx_neg <= !(r_cur_x < r_x1);
               r_sy_neg <= !(r_cur_y < r_y1);
            end
            DRAW: begin
               if (w_step && !w_at_end) begin
                  r_err <= ERR_W'(w_err_nxt);
                  if (w_step_x) r_cur_x <= r_sx_neg ? (r_cur_x - 1'b1) : (r_cur_x + 1'b1);
                  if (w_step_y) r_cur_y <= r_sy_neg ? (r_cur_y - 1'b1) : (r_cur_y + 1'b1);
               end
            end
            default: ;
         endcase
      end
   end

   assign w_pix = '{x: r_cur_x, y: r_cur_y, color: r_color, last: w_draw && w_at_end};

   assign O_CMD_READY = (r_state == IDLE);
   assign O_BUSY      = (r_state != IDLE);
   assign O_PIX_VALID = w_draw && w_in_bounds;
   assign O_PIX_X     = w_pix.x;
   assign O_PIX_Y     = w_pix.y;
   assign O_PIX_COLOR = w_pix.color;
   assign O_PIX_LAST  = w_pix.last;
   assign O_DONE      = w_step && w_at_end;

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: octants, point, backpressure, clipping and mid-line reset.
module tb_line_rasterizer;
   import gpu_pkg::*;

   logic               I_CLK = 1'b0;
   logic               I_RST = 1'b1;
   logic               I_CMD_VALID = 1'b0;
   logic               O_CMD_READY;
   logic [COORD_W-1:0] I_X0 = '0, I_Y0 = '0, I_X1 = '0, I_Y1 = '0;
   logic [COLOR_W-1:0] I_COLOR = '0;
   logic               O_PIX_VALID;
   logic               I_PIX_READY = 1'b1;
   logic [COORD_W-1:0] O_PIX_X, O_PIX_Y;
   logic [COLOR_W-1:0] O_PIX_COLOR;
   logic               O_PIX_LAST, O_DONE, O_BUSY;

   int checks   = 0;
   int failures = 0;
   logic [COLOR_W-1:0] exp_color;

   line_rasterizer dut (
      .I_CLK(I_CLK), .I_RST(I_RST), .I_CMD_VALID(I_CMD_VALID), .O_CMD_READY(O_CMD_READY),
      .I_X0(I_X0), .I_Y0(I_Y0), .I_X1(I_X1), .I_Y1(I_Y1), .I_COLOR(I_COLOR),
      .O_PIX_VALID(O_PIX_VALID), .I_PIX_READY(I_PIX_READY), .O_PIX_X(O_PIX_X), .O_PIX_Y(O_PIX_Y),
      .O_PIX_COLOR(O_PIX_COLOR), .O_PIX_LAST(O_PIX_LAST), .O_DONE(O_DONE), .O_BUSY(O_BUSY)
   );

   always #5 I_CLK = ~I_CLK;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge I_CLK);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input int x0, input int y0, input int x1, input int y1,
                           input logic [COLOR_W-1:0] col);
      I_X0 = COORD_W'(x0); I_Y0 = COORD_W'(y0);
      I_X1 = COORD_W'(x1); I_Y1 = COORD_W'(y1);
      I_COLOR = col; exp_color = col;
      I_CMD_VALID = 1'b1;
      #1 chk("cmd_ready_idle", 32'(O_CMD_READY), 32'd1);
      tick();
      I_CMD_VALID = 1'b0;
      #1;
      chk("setup_ready", 32'(O_CMD_READY), 32'd0);
      chk("setup_valid", 32'(O_PIX_VALID), 32'd0);
      chk("setup_busy",  32'(O_BUSY),      32'd1);
      tick();
   endtask

   task automatic expect_pix(input int x, input int y, input logic last);
      #1;
      chk("pix_valid", 32'(O_PIX_VALID), 32'd1);
      chk("pix_x",     32'(O_PIX_X),     32'(x));
      chk("pix_y",     32'(O_PIX_Y),     32'(y));
      chk("pix_color", 32'(O_PIX_COLOR), 32'(exp_color));
      chk("pix_last",  32'(O_PIX_LAST),  32'(last));
      chk("pix_done",  32'(O_DONE),      32'(last));
      chk("pix_ready", 32'(O_CMD_READY), 32'd0);
      tick();
   endtask

   task automatic expect_idle();
      #1;
      chk("idle_ready", 32'(O_CMD_READY), 32'd1);
      chk("idle_busy",  32'(O_BUSY),      32'd0);
      chk("idle_valid", 32'(O_PIX_VALID), 32'd0);
      chk("idle_done",  32'(O_DONE),      32'd0);
   endtask

   initial begin
      tick(); tick();
      #1;
      chk("rst_ready", 32'(O_CMD_READY), 32'd1);
      chk("rst_valid", 32'(O_PIX_VALID), 32'd0);
      chk("rst_x",     32'(O_PIX_X),     32'd0);
      chk("rst_y",     32'(O_PIX_Y),     32'd0);
      chk("rst_color", 32'(O_PIX_COLOR), 32'd0);
      chk("rst_last",  32'(O_PIX_LAST),  32'd0);
      chk("rst_done",  32'(O_DONE),      32'd0);
      chk("rst_busy",  32'(O_BUSY),      32'd0);
      I_RST = 1'b0;
      tick();

      // Horizontal line
      send_cmd(0, 0, 3, 0, 16'h003F);
      expect_pix(0, 0, 1'b0);
      expect_pix(1, 0, 1'b0);
      expect_pix(2, 0, 1'b0);
      expect_pix(3, 0, 1'b1);
      expect_idle();

      // Steep, x decreasing
      send_cmd(5, 5, 3, 9, 16'hA5C3);
      expect_pix(5, 5, 1'b0);
      expect_pix(4, 6, 1'b0);
      expect_pix(4, 7, 1'b0);
      expect_pix(3, 8, 1'b0);
      expect_pix(3, 9, 1'b1);
      expect_idle();

      // Degenerate point
      send_cmd(7, 7, 7, 7, 16'hFFFF);
      expect_pix(7, 7, 1'b1);
      expect_idle();

      // Backpressure on the diagonal
      send_cmd(0, 0, 2, 2, 16'h1234);
      expect_pix(0, 0, 1'b0);
      I_PIX_READY = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_valid", 32'(O_PIX_VALID), 32'd1);
         chk("bp_x",     32'(O_PIX_X),     32'd1);
         chk("bp_y",     32'(O_PIX_Y),     32'd1);
         chk("bp_color", 32'(O_PIX_COLOR), 32'h1234);
         chk("bp_last",  32'(O_PIX_LAST),  32'd0);
         chk("bp_done",  32'(O_DONE),      32'd0);
         tick();
      end
      I_PIX_READY = 1'b1;
      expect_pix(1, 1, 1'b0);
      expect_pix(2, 2, 1'b1);
      expect_idle();

      // Right-edge clipping
      send_cmd(638, 399, 641, 399, 16'h0F0F);
      expect_pix(638, 399, 1'b0);
      expect_pix(639, 399, 1'b0);
      #1;
      chk("clip640_valid", 32'(O_PIX_VALID), 32'd0);
      chk("clip640_done",  32'(O_DONE),      32'd0);
      chk("clip640_busy",  32'(O_BUSY),      32'd1);
      tick();
      #1;
      chk("clip641_valid", 32'(O_PIX_VALID), 32'd0);
      chk("clip641_done",  32'(O_DONE),      32'd1);
      tick();
      expect_idle();

      // Reset in the middle of a line
      send_cmd(0, 0, 9, 0, 16'h00AA);
      expect_pix(0, 0, 1'b0);
      #1;
      chk("mid_valid", 32'(O_PIX_VALID), 32'd1);
      chk("mid_x",     32'(O_PIX_X),     32'd1);
      I_RST = 1'b1;
      tick();
      I_RST = 1'b0;
      expect_idle();
      send_cmd(0, 5, 1, 5, 16'h5555);
      expect_pix(0, 5, 1'b0);
      expect_pix(1, 5, 1'b1);
      expect_idle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/line_rasterizer.md
Name: line_rasterizer

Overview:
- Bresenham line rasterizer sitting directly upstream of the GPU frame-buffer writer.
- Accepts one line command per handshake: two endpoints plus a 16-bit colour.
- Emits a stream of (x, y, colour) pixels with valid/ready, one pixel per cycle max; the writer converts each pixel to an SRAM address and write.
- Handles all octants; suppresses pixels outside the 640x400 visible frame.

Parameters:
- COORD_W, 10, endpoint/pixel coordinate width (unsigned)
- COLOR_W, 16, pixel colour width ({4'hX,4'hX,4'hX,4'hX} format)
- SCREEN_W, 640, visible columns; x >= SCREEN_W is clipped
- SCREEN_H, 400, visible rows; y >= SCREEN_H is clipped

Ports:
- I_CLK  in  1  single clock
- I_RST  in  1  synchronous active-high reset (one clock; reset is synchronous and active-high)
- I_CMD_VALID  in  1  line command valid
- O_CMD_READY  out  1  block can accept a command
- I_X0, I_Y0, I_X1, I_Y1  in  COORD_W each  start/end endpoints
- I_COLOR  in  COLOR_W  line colour
- O_PIX_VALID  out  1  pixel output valid
- I_PIX_READY  in  1  downstream accepts pixel
- O_PIX_X, O_PIX_Y  out  COORD_W each  pixel coordinate
- O_PIX_COLOR  out  COLOR_W  pixel colour
- O_PIX_LAST  out  1  pixel is the end point (x1,y1)
- O_DONE  out  1  one-cycle pulse when the line completes
- O_BUSY  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; O_CMD_READY=1; O_PIX_VALID=0; O_PIX_X/Y=0; O_PIX_COLOR=0; O_PIX_LAST=0; O_DONE=0; O_BUSY=0.
- Reset mid-line aborts immediately; no O_DONE is issued.
- States: IDLE, SETUP, DRAW.
- IDLE: O_CMD_READY=1. On I_CMD_VALID, latch endpoints and colour, then go to SETUP.
- SETUP (1 cycle):
  - dx = |x1-x0| (unsigned, COORD_W+1 bits)
  - dy = -|y1-y0| (signed)
  - sx = +1 if x0<x1 else -1; sy = +1 if y0<y1 else -1
  - err = dx+dy, held in a COORD_W+3-bit signed register
  - cur = (x0, y0); go to DRAW.
- DRAW: the current pixel is presented combinationally from cur.
  - O_PIX_VALID = in-bounds, where in-bounds is (cur_x < SCREEN_W) and (cur_y < SCREEN_H).
  - Step occurs when (O_PIX_VALID && I_PIX_READY) || !in-bounds. Clipped pixels are skipped in one cycle without handshake.
  - Step rule, with e2 = 2*err (COORD_W+4 signed):
    - if e2 >= dy: err += dy, x += sx
    - if e2 <= dx: err += dx, y += sy
    - Both updates combine in the same cycle.
  - If cur == (x1, y1) on a step: no coordinate update, O_DONE=1 that same cycle, next state IDLE.
- O_PIX_LAST = (cur == (x1, y1)) while in DRAW.
- Latency: first pixel valid 2 cycles after the command handshake. Throughput is 1 pixel/cycle with I_PIX_READY held high.
- O_CMD_READY=0 in SETUP and DRAW; commands are not queued. A new command is accepted the cycle after O_DONE at the earliest.
- Backpressure: while O_PIX_VALID && !I_PIX_READY, O_PIX_X/Y/COLOR/LAST hold stable.
- Degenerate line (x0,y0)==(x1,y1): exactly one pixel with LAST=1, or none if clipped; O_DONE always pulses.
- Endpoint coordinates up to 2^COORD_W-1 are legal. Clipping never alters the stepping sequence.

Decomposition:
- Shared package gpu_pkg holds:
  - SCREEN_W, SCREEN_H, COORD_W, COLOR_W constants
  - rast_state_t enum {IDLE, SETUP, DRAW}
  - pixel struct {x, y, color, last}
- Single module; no sub-module. The step datapath is small enough to stay inline.

Test Plan:
- Horizontal (0,0)->(3,0), colour 16'h003F, ready=1: pixels x=0,1,2,3 at y=0 on 4 consecutive cycles, first valid 2 cycles after accept; LAST and DONE on the 4th pixel.
- Steep reverse (5,5)->(3,9): exactly (5,5),(4,6),(4,7),(3,8),(3,9); LAST on (3,9); O_CMD_READY=0 throughout.
- Point (7,7)->(7,7): single pixel (7,7), LAST=1, DONE same cycle; back to IDLE next cycle.
- Backpressure on (0,0)->(2,2): hold I_PIX_READY=0 for 3 cycles on pixel (1,1): outputs stable, no skip; sequence (0,0),(1,1),(2,2) completes.
- Clipping (638,399)->(641,399): only x=638,639 emitted; DONE pulses on the cycle x=641 is skipped; LAST never seen valid.
- Reset asserted at the 2nd pixel of (0,0)->(9,0): next cycle O_PIX_VALID=0, O_BUSY=0, O_CMD_READY=1, no DONE. A new command (0,5)->(1,5) then draws correctly.
